// File: rtl/snake_move_ctrl.sv
// Snake head movement controller: 2-deep turn queue, per-tick head advance, wall death.
// Define SNAKE_WRAP_EN to make the head wrap around the grid edges instead of dying.
module snake_move_ctrl #(
  parameter int GRID_W  = 40,
  parameter int GRID_H  = 30,
  parameter int START_X = 20,
  parameter int START_Y = 15,
  parameter int CW      = 6
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          tick,
  input  logic          start,
  input  logic          btn_up,
  input  logic          btn_right,
  input  logic          btn_down,
  input  logic          btn_left,
  output logic [CW-1:0] head_x,
  output logic [CW-1:0] head_y,
  output logic [1:0]    dir,
  output logic          moved,
  output logic          running,
  output logic          game_over
);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DEAD} state_t;

  localparam logic [1:0] D_UP    = 2'b00;
  localparam logic [1:0] D_RIGHT = 2'b01;
  localparam logic [1:0] D_DOWN  = 2'b10;
  localparam logic [1:0] D_LEFT  = 2'b11;

  localparam logic [CW-1:0] X_START = CW'(START_X);
  localparam logic [CW-1:0] Y_START = CW'(START_Y);
  localparam logic [CW-1:0] X_MAX   = CW'(GRID_W - 1);
  localparam logic [CW-1:0] Y_MAX   = CW'(GRID_H - 1);
  localparam logic [CW-1:0] ONE     = CW'(1);

  state_t        state_q, state_d;
  logic [CW-1:0] head_x_q, head_x_d, head_y_q, head_y_d;
  logic [1:0]    dir_q, dir_d;
  logic [1:0]    q0_q, q0_d, q1_q, q1_d;
  logic [1:0]    cnt_q, cnt_d;
  logic          moved_q, moved_d, running_q, running_d, game_over_q, game_over_d;

  logic          cand_vld, pop, push;
  logic [1:0]    cand, ref_dir, nxt_dir;
  logic [CW-1:0] nx, ny;
`ifndef SNAKE_WRAP_EN
  logic          wall;
`endif

  always_comb begin
    cand_vld = btn_up | btn_right | btn_down | btn_left;
    if (btn_up)         cand = D_UP;
    else if (btn_right) cand = D_RIGHT;
    else if (btn_down)  cand = D_DOWN;
    else                cand = D_LEFT;

    // Turns are validated against the last direction the snake will have taken.
    ref_dir = (cnt_q == 2'd2) ? q1_q : (cnt_q == 2'd1) ? q0_q : dir_q;
    pop     = tick && (cnt_q != 2'd0);
    nxt_dir = pop ? q0_q : dir_q;
    push    = cand_vld && (cand != ref_dir) && (cand != (ref_dir ^ 2'b10)) &&
              ((cnt_q != 2'd2) || pop);

    nx = head_x_q;
    ny = head_y_q;
    case (nxt_dir)
      D_UP:    ny = (head_y_q == '0)    ? Y_MAX : head_y_q - ONE;
      D_RIGHT: nx = (head_x_q == X_MAX) ? '0    : head_x_q + ONE;
      D_DOWN:  ny = (head_y_q == Y_MAX) ? '0    : head_y_q + ONE;
      default: nx = (head_x_q == '0)    ? X_MAX : head_x_q - ONE;
    endcase
`ifndef SNAKE_WRAP_EN
    wall = ((nxt_dir == D_UP)    && (head_y_q == '0))    ||
           ((nxt_dir == D_RIGHT) && (head_x_q == X_MAX)) ||
           ((nxt_dir == D_DOWN)  && (head_y_q == Y_MAX)) ||
           ((nxt_dir == D_LEFT)  && (head_x_q == '0));
`endif

    state_d  = state_q;
    head_x_d = head_x_q;
    head_y_d = head_y_q;
    dir_d    = dir_q;
    q0_d     = q0_q;
    q1_d     = q1_q;
    cnt_d    = cnt_q;
    moved_d  = 1'b0;

    case (state_q)
      ST_RUN: begin
        if (tick) begin
          dir_d = nxt_dir;
`ifdef SNAKE_WRAP_EN
          head_x_d = nx;
          head_y_d = ny;
          moved_d  = 1'b1;
`else
          if (wall) begin
            state_d = ST_DEAD;
          end else begin
            head_x_d = nx;
            head_y_d = ny;
            moved_d  = 1'b1;
          end
`endif
        end
        // Pop sees the pre-push queue; a same-edge push lands behind the shifted entry.
        case ({pop, push})
          2'b10: begin
            q0_d  = q1_q;
            cnt_d = cnt_q - 2'd1;
          end
          2'b01: begin
            if (cnt_q == 2'd0) q0_d = cand;
            else               q1_d = cand;
            cnt_d = cnt_q + 2'd1;
          end
          2'b11: begin
            if (cnt_q == 2'd1) begin
              q0_d = cand;
            end else begin
              q0_d = q1_q;
              q1_d = cand;
            end
          end
          default: ;
        endcase
      end
      default: begin
        if (start) begin
          state_d  = ST_RUN;
          head_x_d = X_START;
          head_y_d = Y_START;
          dir_d    = D_RIGHT;
          cnt_d    = 2'd0;
        end
      end
    endcase

    running_d   = (state_d == ST_RUN);
    game_over_d = (state_d == ST_DEAD);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      head_x_q    <= X_START;
      head_y_q    <= Y_START;
      dir_q       <= D_RIGHT;
      q0_q        <= D_UP;
      q1_q        <= D_UP;
      cnt_q       <= 2'd0;
      moved_q     <= 1'b0;
      running_q   <= 1'b0;
      game_over_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      head_x_q    <= head_x_d;
      head_y_q    <= head_y_d;
      dir_q       <= dir_d;
      q0_q        <= q0_d;
      q1_q        <= q1_d;
      cnt_q       <= cnt_d;
      moved_q     <= moved_d;
      running_q   <= running_d;
      game_over_q <= game_over_d;
    end
  end

  assign head_x    = head_x_q;
  assign head_y    = head_y_q;
  assign dir       = dir_q;
  assign moved     = moved_q;
  assign running   = running_q;
  assign game_over = game_over_q;

endmodule

// File: tb/tb_snake_move_ctrl.sv
// Bench for snake_move_ctrl: vector table, directed corner sequences, random run vs. a queue-based model.
module tb_snake_move_ctrl;

  localparam int GW = 40, GH = 30, SX = 20, SY = 15;

  logic       clk, rst, tick, start, btn_up, btn_right, btn_down, btn_left;
  logic [5:0] head_x, head_y;
  logic [1:0] dir;
  logic       moved, running, game_over;

  snake_move_ctrl dut (
    .clk(clk), .rst(rst), .tick(tick), .start(start),
    .btn_up(btn_up), .btn_right(btn_right), .btn_down(btn_down), .btn_left(btn_left),
    .head_x(head_x), .head_y(head_y), .dir(dir),
    .moved(moved), .running(running), .game_over(game_over)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Model: mode 0 idle, 1 playing, 2 dead; pending turns kept in a queue.
  int m_mode, m_x, m_y, m_dir, m_moved;
  int m_q[$];

  typedef struct {
    bit       t;
    bit       s;
    bit [3:0] b;   // {up, right, down, left}
    int ex, ey, ed, em, er, eg;
  } vec_t;
  vec_t tbl[16];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_x = SX; m_y = SY; m_dir = 1; m_moved = 0;
    m_q.delete();
  endtask

  task automatic model_step(input bit t, input bit s, input bit [3:0] b);
    int cand, refd, nx, ny;
    bit took, acc, hit;
    m_moved = 0;
    if (m_mode != 1) begin
      if (s) begin
        m_mode = 1; m_x = SX; m_y = SY; m_dir = 1;
        m_q.delete();
      end
    end else begin
      cand = b[3] ? 0 : b[2] ? 1 : b[1] ? 2 : b[0] ? 3 : -1;
      refd = (m_q.size() > 0) ? m_q[m_q.size()-1] : m_dir;
      took = t && (m_q.size() > 0);
      acc  = (cand >= 0) && (cand != refd) && (cand != (refd + 2) % 4) &&
             ((m_q.size() < 2) || took);
      if (t) begin
        if (m_q.size() > 0) m_dir = m_q.pop_front();
        nx = m_x + ((m_dir == 1) ? 1 : (m_dir == 3) ? -1 : 0);
        ny = m_y + ((m_dir == 2) ? 1 : (m_dir == 0) ? -1 : 0);
        hit = (nx < 0) || (nx >= GW) || (ny < 0) || (ny >= GH);
`ifdef SNAKE_WRAP_EN
        hit = 1'b0;
        nx = (nx + GW) % GW;
        ny = (ny + GH) % GH;
`endif
        if (hit) m_mode = 2;
        else begin
          m_x = nx; m_y = ny; m_moved = 1;
        end
      end
      if (acc) m_q.push_back(cand);
    end
  endtask

  task automatic check_model();
    chk("head_x", int'(head_x), m_x);
    chk("head_y", int'(head_y), m_y);
    chk("dir", int'(dir), m_dir);
    chk("moved", int'(moved), m_moved);
    chk("running", int'(running), (m_mode == 1) ? 1 : 0);
    chk("game_over", int'(game_over), (m_mode == 2) ? 1 : 0);
  endtask

  task automatic step(input bit t, input bit s, input bit [3:0] b);
    tick = t; start = s;
    {btn_up, btn_right, btn_down, btn_left} = b;
    @(posedge clk);
    model_step(t, s, b);
    #1;
    check_model();
    tick = 0; start = 0;
    {btn_up, btn_right, btn_down, btn_left} = 4'b0000;
  endtask

  task automatic do_reset();
    #3 rst = 1'b1;
    #1;
    chk("rst_x", int'(head_x), SX);
    chk("rst_y", int'(head_y), SY);
    chk("rst_dir", int'(dir), 1);
    chk("rst_flags", int'({moved, running, game_over}), 0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 4'b0000);
  endtask

  initial begin
    rst = 1'b1; tick = 0; start = 0;
    {btn_up, btn_right, btn_down, btn_left} = 4'b0000;
    model_reset();

    //            t s  btns     x   y  d m r g
    tbl[0]  = '{0, 0, 4'b0000, 20, 15, 1, 0, 0, 0};
    tbl[1]  = '{0, 1, 4'b0000, 20, 15, 1, 0, 1, 0};
    tbl[2]  = '{1, 0, 4'b0000, 21, 15, 1, 1, 1, 0};
    tbl[3]  = '{0, 0, 4'b0000, 21, 15, 1, 0, 1, 0};
    tbl[4]  = '{1, 0, 4'b0000, 22, 15, 1, 1, 1, 0};
    tbl[5]  = '{1, 0, 4'b0000, 23, 15, 1, 1, 1, 0};
    tbl[6]  = '{0, 0, 4'b0001, 23, 15, 1, 0, 1, 0};
    tbl[7]  = '{1, 0, 4'b0000, 24, 15, 1, 1, 1, 0};
    tbl[8]  = '{0, 0, 4'b1000, 24, 15, 1, 0, 1, 0};
    tbl[9]  = '{0, 0, 4'b0001, 24, 15, 1, 0, 1, 0};
    tbl[10] = '{0, 0, 4'b0010, 24, 15, 1, 0, 1, 0};
    tbl[11] = '{1, 0, 4'b0000, 24, 14, 0, 1, 1, 0};
    tbl[12] = '{1, 0, 4'b0000, 23, 14, 3, 1, 1, 0};
    tbl[13] = '{1, 0, 4'b0000, 22, 14, 3, 1, 1, 0};
    tbl[14] = '{1, 0, 4'b0010, 21, 14, 3, 1, 1, 0};
    tbl[15] = '{1, 0, 4'b0000, 21, 15, 2, 1, 1, 0};

    repeat (2) @(posedge clk);
    #1;
    chk("reset_state", int'({head_x, head_y, dir, moved, running, game_over}),
        int'({6'd20, 6'd15, 2'b01, 3'b000}));
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 16; i++) begin
      step(tbl[i].t, tbl[i].s, tbl[i].b);
      chk($sformatf("tbl%0d_x", i), int'(head_x), tbl[i].ex);
      chk($sformatf("tbl%0d_y", i), int'(head_y), tbl[i].ey);
      chk($sformatf("tbl%0d_dir", i), int'(dir), tbl[i].ed);
      chk($sformatf("tbl%0d_moved", i), int'(moved), tbl[i].em);
      chk($sformatf("tbl%0d_run", i), int'(running), tbl[i].er);
      chk($sformatf("tbl%0d_go", i), int'(game_over), tbl[i].eg);
    end

    // Run up into the top wall.
    do_reset();
    step(1'b0, 1'b1, 4'b0000);
    step(1'b0, 1'b0, 4'b1000);
    ticks(15);
    chk("top_y0", int'(head_y), 0);
    chk("top_alive", int'(game_over), 0);
    step(1'b1, 1'b0, 4'b0000);
`ifndef SNAKE_WRAP_EN
    chk("top_dead", int'({game_over, running}), 2);
    chk("top_hold", int'({head_x, head_y}), int'({6'd20, 6'd0}));
    step(1'b1, 1'b0, 4'b1000);
    chk("dead_hold", int'({head_x, head_y, game_over}), int'({6'd20, 6'd0, 1'b1}));
    step(1'b0, 1'b1, 4'b0000);
    chk("restart", int'({head_x, head_y, dir, running, game_over}),
        int'({6'd20, 6'd15, 2'b01, 2'b10}));
`else
    chk("top_wrap", int'({head_y, moved, game_over}), int'({6'd29, 2'b10}));
`endif

    // Tick and turn on the same edge with the queue empty.
    do_reset();
    step(1'b0, 1'b1, 4'b0000);
    step(1'b1, 1'b0, 4'b0010);
    chk("same_edge_move", int'({head_x, head_y, dir}), int'({6'd21, 6'd15, 2'b01}));
    step(1'b1, 1'b0, 4'b0000);
    chk("same_edge_turn", int'({head_x, head_y, dir}), int'({6'd21, 6'd16, 2'b10}));

    // Right-hand wall.
    do_reset();
    step(1'b0, 1'b1, 4'b0000);
    ticks(19);
    chk("right_x39", int'(head_x), 39);
    step(1'b1, 1'b0, 4'b0000);
`ifdef SNAKE_WRAP_EN
    chk("right_wrap", int'({head_x, head_y, moved, game_over}), int'({6'd0, 6'd15, 2'b10}));
`else
    chk("right_dead", int'({head_x, head_y, moved, game_over}), int'({6'd39, 6'd15, 2'b01}));
`endif

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      bit [3:0] b;
      b[3] = ($urandom_range(0, 7) == 0);
      b[2] = ($urandom_range(0, 7) == 0);
      b[1] = ($urandom_range(0, 7) == 0);
      b[0] = ($urandom_range(0, 7) == 0);
      step($urandom_range(0, 2) == 0, $urandom_range(0, 19) == 0, b);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
